// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 controller-sequencer: widths, opcodes,
// control-word bit positions and the machine-cycle state encoding.
package sap_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned CON_W    = 12;
    localparam int unsigned TSTATE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

    localparam int unsigned CON_CP = 11;
    localparam int unsigned CON_EP = 10;
    localparam int unsigned CON_LM = 9;
    localparam int unsigned CON_CE = 8;
    localparam int unsigned CON_LI = 7;
    localparam int unsigned CON_EI = 6;
    localparam int unsigned CON_LA = 5;
    localparam int unsigned CON_EA = 4;
    localparam int unsigned CON_SU = 3;
    localparam int unsigned CON_EU = 2;
    localparam int unsigned CON_LB = 1;
    localparam int unsigned CON_LO = 0;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StT1   = 3'd1,
        StT2   = 3'd2,
        StT3   = 3'd3,
        StT4   = 3'd4,
        StT5   = 3'd5,
        StT6   = 3'd6,
        StHalt = 3'd7
    } state_e;

    function automatic logic [CON_W-1:0] con_bit(input int unsigned idx);
        logic [CON_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/sap_control_decoder.sv
// Combinational decode of (phase, opcode) into the 12-bit control word.
// IDLE and HALT, and any unlisted opcode in T4..T6, produce an all-zero word.
module sap_control_decoder
    import sap_pkg::*;
(
    input  state_e              state_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CON_W-1:0]    con_o
);

    always_comb begin
        con_o = '0;
        unique case (state_i)
            StT1: con_o = con_bit(CON_EP) | con_bit(CON_LM);
            StT2: con_o = con_bit(CON_CP);
            StT3: con_o = con_bit(CON_CE) | con_bit(CON_LI);
            StT4: begin
                if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    con_o = con_bit(CON_EI) | con_bit(CON_LM);
                end else if (opcode_i == OP_OUT) begin
                    con_o = con_bit(CON_EA) | con_bit(CON_LO);
                end
            end
            StT5: begin
                if (opcode_i == OP_LDA) begin
                    con_o = con_bit(CON_CE) | con_bit(CON_LA);
                end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                    con_o = con_bit(CON_CE) | con_bit(CON_LB);
                end
            end
            StT6: begin
                if (opcode_i == OP_ADD) begin
                    con_o = con_bit(CON_EU) | con_bit(CON_LA);
                end else if (opcode_i == OP_SUB) begin
                    con_o = con_bit(CON_SU) | con_bit(CON_EU) | con_bit(CON_LA);
                end
            end
            StIdle, StHalt: con_o = '0;
            default:        con_o = '0;
        endcase
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: steps IDLE -> T1..T6 while run is high, stalls
// with a zeroed control word when run is low, and parks in HALT until reset.
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                run_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CON_W-1:0]    con_o,
    output logic [TSTATE_W-1:0] t_state_o,
    output logic                halted_o
);

    state_e           state_q, state_d;
    logic [CON_W-1:0] dec_con;

    sap_control_decoder u_decoder (
        .state_i  (state_q),
        .opcode_i (opcode_i),
        .con_o    (dec_con)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_i) begin
            unique case (state_q)
                StIdle:  state_d = StT1;
                StT1:    state_d = StT2;
                StT2:    state_d = StT3;
                StT3:    state_d = StT4;
                StT4:    state_d = (opcode_i == OP_HLT) ? StHalt : StT5;
                StT5:    state_d = StT6;
                StT6:    state_d = StT1;
                StHalt:  state_d = StHalt;
                default: state_d = StIdle;
            endcase
        end
    end

    // A stalled phase keeps its t_state but must not assert any control line.
    always_comb begin
        con_o     = run_i ? dec_con : '0;
        t_state_o = '0;
        unique case (state_q)
            StT1:    t_state_o = 6'b000001;
            StT2:    t_state_o = 6'b000010;
            StT3:    t_state_o = 6'b000100;
            StT4:    t_state_o = 6'b001000;
            StT5:    t_state_o = 6'b010000;
            StT6:    t_state_o = 6'b100000;
            default: t_state_o = '0;
        endcase
        halted_o = (state_q == StHalt);
    end

endmodule
